// File: rtl/game_ctl.sv
// game_ctl: game state machine with frame-tick timing, hit scoring and per-state text/click-window setup.
module game_ctl #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int GAME_SECONDS   = 30,
  parameter int SCORE_HOLD_SEC = 5
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        rect_clicked,
  input  logic        uart_start,
  input  logic        hit,
  output logic [1:0]  state,
  output logic [11:0] width_start,
  output logic [11:0] height_start,
  output logic [10:0] hstart,
  output logic [10:0] vstart,
  output logic [10:0] hlength,
  output logic [10:0] vlength,
  output logic [1:0]  text_sel,
  output logic [5:0]  sec_left,
  output logic [7:0]  score
);
  typedef enum logic [1:0] {IDLE, WAIT, GAME, SCORE} st_e;
  st_e        st_q, st_d;
  logic [2:0] in_q, prev_q;
  logic [1:0] arm_q;
  logic [6:0] frame_q, frame_d;
  logic [5:0] hold_q, hold_d, sec_d;
  logic [7:0] score_d;
  logic       click, tick, hit_ev, frame_wrap, game_n;
  // arm_q keeps inputs already high at reset release from looking like fresh edges
  assign {click, tick, hit_ev} = in_q & ~prev_q & {3{arm_q[1]}};
  assign frame_wrap = tick && frame_q == 7'(FRAMES_PER_SEC - 1);
  assign game_n = !rst && st_d == GAME;
  assign state = st_q;
  assign text_sel = st_q;
  always_comb begin
    st_d = st_q;
    frame_d = frame_q;
    hold_d = hold_q;
    sec_d = sec_left;
    score_d = score;
    case (st_q)
      IDLE: if (click) begin
        st_d = WAIT;
        score_d = '0;
      end
      WAIT: if (click && uart_start) begin
        st_d = GAME;
        sec_d = 6'(GAME_SECONDS);
        frame_d = '0;
      end
      GAME: begin
        if (hit_ev && score != 8'hff) score_d = score + 8'd1;
        if (click) st_d = IDLE;
        else if (tick) begin
          frame_d = frame_wrap ? '0 : frame_q + 7'd1;
          if (frame_wrap) begin
            sec_d = sec_left - 6'd1;
            if (sec_left == 6'd1) begin
              st_d = SCORE;
              hold_d = 6'(SCORE_HOLD_SEC);
            end
          end
        end
      end
      default: if (click) st_d = IDLE;
      else if (tick) begin
        frame_d = frame_wrap ? '0 : frame_q + 7'd1;
        if (frame_wrap) begin
          hold_d = hold_q - 6'd1;
          if (hold_q == 6'd1) st_d = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge pclk) begin
    width_start <= game_n ? 12'd700 : 12'd380;
    height_start <= game_n ? 12'd20 : 12'd186;
    hstart <= game_n ? 11'd700 : 11'd380;
    vstart <= game_n ? 11'd20 : 11'd186;
    hlength <= game_n ? 11'd80 : 11'd300;
    vlength <= game_n ? 11'd40 : 11'd100;
    if (rst) begin
      st_q <= IDLE;
      in_q <= '0;
      prev_q <= '0;
      arm_q <= '0;
      frame_q <= '0;
      hold_q <= '0;
      sec_left <= '0;
      score <= '0;
    end else begin
      st_q <= st_d;
      in_q <= {rect_clicked, vsync_in, hit};
      prev_q <= in_q;
      arm_q <= {arm_q[0], 1'b1};
      frame_q <= frame_d;
      hold_q <= hold_d;
      sec_left <= sec_d;
      score <= score_d;
    end
  end
endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: directed stimulus pushes expected outputs to a scoreboard; a negedge monitor pops and compares.
module tb_game_ctl;
  logic        pclk = 0, rst = 1, vsync_in = 0, rect_clicked = 0, uart_start = 0, hit = 0;
  logic [1:0]  state, text_sel;
  logic [11:0] width_start, height_start;
  logic [10:0] hstart, vstart, hlength, vlength;
  logic [5:0]  sec_left;
  logic [7:0]  score;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic [1:0]  st;
    logic [5:0]  sec;
    logic [7:0]  sc;
    logic [11:0] ws, hs;
    logic [10:0] hst, vst, hl, vl;
  } exp_t;
  exp_t  sb[$];
  string nm[$];

  game_ctl #(.FRAMES_PER_SEC(2), .GAME_SECONDS(3), .SCORE_HOLD_SEC(2)) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .rect_clicked(rect_clicked),
    .uart_start(uart_start), .hit(hit), .state(state), .width_start(width_start),
    .height_start(height_start), .hstart(hstart), .vstart(vstart), .hlength(hlength),
    .vlength(vlength), .text_sel(text_sel), .sec_left(sec_left), .score(score)
  );

  always #5 pclk = ~pclk;

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [1:0] st, input logic [5:0] sec, input logic [7:0] sc);
    exp_t e;
    logic g;
    g = (st == 2'd2);
    e.st = st; e.sec = sec; e.sc = sc;
    e.ws = g ? 12'd700 : 12'd380; e.hs = g ? 12'd20 : 12'd186;
    e.hst = g ? 11'd700 : 11'd380; e.vst = g ? 11'd20 : 11'd186;
    e.hl = g ? 11'd80 : 11'd300; e.vl = g ? 11'd40 : 11'd100;
    sb.push_back(e);
    nm.push_back(name);
  endtask

  task automatic pulse(input logic c, input logic v, input logic h);
    rect_clicked = c; vsync_in = v; hit = h;
    step(1);
    rect_clicked = 0; vsync_in = 0; hit = 0;
    step(1);
  endtask

  always @(negedge pclk) begin
    if (sb.size() > 0) begin
      exp_t e;
      exp_t a;
      string n;
      e = sb.pop_front();
      n = nm.pop_front();
      a = '{state, sec_left, score, width_start, height_start, hstart, vstart, hlength, vlength};
      checks++;
      if (a != e || text_sel != e.st) begin
        failures++;
        $display("FAIL %s: got st=%0d ts=%0d sec=%0d score=%0d org=(%0d,%0d) win=(%0d,%0d,%0d,%0d) want st=%0d ts=%0d sec=%0d score=%0d org=(%0d,%0d) win=(%0d,%0d,%0d,%0d)",
          n, state, text_sel, sec_left, score, width_start, height_start, hstart, vstart, hlength, vlength,
          e.st, e.st, e.sec, e.sc, e.ws, e.hs, e.hst, e.vst, e.hl, e.vl);
      end
    end
  end

  initial begin
    step(3);
    expect_out("reset_held", 0, 0, 0);
    step(1);
    rst = 0;
    step(4);
    expect_out("reset_idle", 0, 0, 0);
    pulse(1, 0, 0);
    expect_out("idle_to_wait", 1, 0, 0);
    pulse(0, 0, 1);
    expect_out("wait_hit_ignored", 1, 0, 0);
    pulse(1, 0, 0);
    expect_out("wait_no_uart", 1, 0, 0);
    uart_start = 1;
    pulse(1, 0, 0);
    expect_out("wait_to_game", 2, 3, 0);
    for (int i = 1; i <= 6; i++) begin
      pulse(0, 1, i == 1 || i == 3 || i == 5 || i == 6);
      if (i == 2) expect_out("game_sec2", 2, 2, 1);
      if (i == 4) expect_out("game_sec1", 2, 1, 2);
      if (i == 6) expect_out("game_expire", 3, 0, 4);
    end
    pulse(0, 0, 1);
    expect_out("score_hit_ignored", 3, 0, 4);
    for (int i = 1; i <= 3; i++) pulse(0, 1, 0);
    expect_out("score_hold_3ticks", 3, 0, 4);
    pulse(0, 1, 0);
    expect_out("score_timeout", 0, 0, 4);
    pulse(1, 0, 0);
    expect_out("idle_clear_score", 1, 0, 0);
    pulse(1, 0, 0);
    expect_out("game_again", 2, 3, 0);
    for (int i = 1; i <= 5; i++) pulse(0, 1, 0);
    expect_out("game_5ticks", 2, 1, 0);
    pulse(1, 1, 0);
    expect_out("click_beats_expiry", 0, 1, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    expect_out("game_for_sat", 2, 3, 0);
    for (int i = 0; i < 254; i++) pulse(0, 0, 1);
    expect_out("score_254", 2, 3, 254);
    for (int i = 0; i < 46; i++) pulse(0, 0, 1);
    expect_out("score_sat_255", 2, 3, 255);
    pulse(0, 1, 0);
    rect_clicked = 1;
    rst = 1;
    step(2);
    expect_out("reset_in_game", 0, 0, 0);
    step(1);
    rst = 0;
    step(5);
    expect_out("held_click_no_event", 0, 0, 0);
    rect_clicked = 0;
    step(3);
    expect_out("release_no_event", 0, 0, 0);
    pulse(1, 0, 0);
    expect_out("post_reset_wait", 1, 0, 0);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    expect_out("post_reset_game", 2, 3, 0);
    pulse(0, 1, 0);
    expect_out("post_reset_frame0", 2, 2, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: got pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/game_ctl.md
GAME_CTL -- requirements
Module: game_ctl

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60, vsync frames per game second (range 1..127).
REQ-002 Parameter GAME_SECONDS, default 30, GAME duration in seconds (range 1..63).
REQ-003 Parameter SCORE_HOLD_SEC, default 5, seconds SCORE is shown before auto-return to IDLE (range 1..63).
REQ-004 pclk  input  1  the only clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 vsync_in  input  1  VGA vsync; its rising edge is the frame tick.
REQ-007 rect_clicked  input  1  level from click_ctl; mouse-left held inside the current click window.
REQ-008 uart_start  input  1  level; remote player ready.
REQ-009 hit  input  1  level; target hit by player; one score per rising edge.
REQ-010 state  output  2  current state: IDLE=0, WAIT=1, GAME=2, SCORE=3.
REQ-011 width_start, height_start  output  12 each  text-rectangle origin for draw_rect_char.
REQ-012 hstart, vstart, hlength, vlength  output  11 each  click window for click_ctl.
REQ-013 text_sel  output  2  char ROM select: 0=PLAY, 1=WAIT, 2=STOP, 3=SCORE.
REQ-014 sec_left  output  6  remaining game seconds.
REQ-015 score  output  8  hits in the current or last game.

Function
REQ-016 The block SHALL register all outputs; none combinational from inputs.
REQ-017 The block SHALL register vsync_in, rect_clicked and hit once each, and SHALL form click/tick/hit events as in & ~prev (single-cycle).
REQ-018 An event seen at edge N SHALL be reflected in the outputs after edge N+1 (1-cycle latency).
REQ-019 IDLE->WAIT on click event; the block SHALL clear score to 0 on that transition.
REQ-020 WAIT->GAME on click event while uart_start=1; the block SHALL load sec_left=GAME_SECONDS and frame_cnt=0; click while uart_start=0 SHALL be ignored.
REQ-021 GAME->IDLE on click event (stop button).
REQ-022 In GAME, each tick SHALL increment frame_cnt; at FRAMES_PER_SEC-1 it SHALL wrap to 0 and decrement sec_left.
REQ-023 GAME->SCORE when sec_left would go 1->0; sec_left SHALL read 0 in SCORE.
REQ-024 In GAME each hit event SHALL increment score, saturating at 255.
REQ-025 Simultaneous events in GAME: click beats expiry (go IDLE); a hit in the expiry cycle SHALL be counted.
REQ-026 On entering SCORE the block SHALL load hold_cnt=SCORE_HOLD_SEC, frame_cnt=0 and decrement hold_cnt every FRAMES_PER_SEC ticks.
REQ-027 SCORE->IDLE on click event or hold_cnt reaching 0, whichever first; score SHALL hold until the next IDLE->WAIT.
REQ-028 Hit events outside GAME SHALL be ignored; ticks outside GAME/SCORE SHALL not alter counters.
REQ-029 Per-state configuration, registered alongside state:
 - IDLE: origin (380,186), window (380,186,300,100), text_sel 0.
 - WAIT: origin (380,186), window (380,186,300,100), text_sel 1.
 - GAME: origin (700,20), window (700,20,80,40), text_sel 2.
 - SCORE: origin (380,186), window (380,186,300,100), text_sel 3.
REQ-030 Unreachable state encodings SHALL not exist; the 2-bit encoding is full.

Reset
REQ-031 On rst=1 at a pclk edge the block SHALL enter IDLE with IDLE configuration, sec_left=0, score=0, frame_cnt=0, hold_cnt=0, and all edge-detect registers=0.
REQ-032 Reset in any state, mid-count, SHALL take effect at that edge, overriding all events.
REQ-033 An input held high through reset release SHALL not produce an event.

Verification (FRAMES_PER_SEC=2, GAME_SECONDS=3, SCORE_HOLD_SEC=2)
REQ-034 Reset, click pulse -> state 1, text_sel 1, score 0 one cycle after click sampled.
REQ-035 WAIT, click with uart_start=0 -> stays 1; click with uart_start=1 -> state 2, sec_left 3, window (700,20,80,40).
REQ-036 GAME, 6 vsync edges, 4 hit pulses -> sec_left 2,1 then state 3, sec_left 0, score 4.
REQ-037 GAME, click and final tick on the same edge -> state 0, not 3.
REQ-038 SCORE, 4 vsync edges, no click -> state 0, score still 4; 300 hit pulses during a game -> score 255.
REQ-039 rst asserted in GAME with rect_clicked held high -> state 0, all counters 0, no transition on release.
